vpp_avg_filter: RTL and testbench



---
 rtl/vpp_avg_filter.sv | 134 +++++++++++++
 tb/tb_vpp_avg_filter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpp_avg_filter.sv
// Averages 2^AVG_LOG2 Vpp measurements after discarding settling samples.
// Optional macro VPP_AVG_ROUND_EN selects round-to-nearest with saturation.
module vpp_avg_filter #(
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned AVG_LOG2    = 3,
   parameter int unsigned DISCARD_N   = 2,
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] vpp_in,
   input  logic              vpp_found,
   output logic [DATA_W-1:0] vpp_avg,
   output logic              avg_valid,
   output logic              busy,
   output logic              timeout
);

   localparam int unsigned AccW  = DATA_W + AVG_LOG2;
   localparam int unsigned NW    = AVG_LOG2 + 1;
   localparam int unsigned TcntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYC - 1);
   localparam logic [3:0]       DcntLast = 4'((DISCARD_N > 0) ? DISCARD_N - 1 : 0);
   localparam logic [NW-1:0]    NLast    = NW'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {StIdle, StDiscard, StAccum, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          sync_q;
   logic [AccW-1:0]     acc_q, acc_d;
   logic [NW-1:0]       n_q, n_d;
   logic [3:0]          dcnt_q, dcnt_d;
   logic [TcntW-1:0]    tcnt_q, tcnt_d;
   logic [DATA_W-1:0]   vpp_avg_q, vpp_avg_d;
   logic                avg_valid_q, avg_valid_d;
   logic                timeout_q, timeout_d;
   logic                fe;
   logic [DATA_W-1:0]   avg_calc;

   // Two metastability flops plus one edge register on the strobe.
   assign fe = sync_q[1] & ~sync_q[2];

`ifdef VPP_AVG_ROUND_EN
   localparam logic [AccW:0] Half = (AccW+1)'(1 << (AVG_LOG2 - 1));
   logic [AccW:0]   round_sum;
   logic [DATA_W:0] round_shr;

   assign round_sum = {1'b0, acc_q} + Half;
   assign round_shr = (DATA_W+1)'(round_sum >> AVG_LOG2);
   assign avg_calc  = round_shr[DATA_W] ? '1 : round_shr[DATA_W-1:0];
`else
   assign avg_calc = DATA_W'(acc_q >> AVG_LOG2);
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      n_d         = n_q;
      dcnt_d      = dcnt_q;
      tcnt_d      = tcnt_q;
      vpp_avg_d   = vpp_avg_q;
      avg_valid_d = avg_valid_q;
      timeout_d   = timeout_q;
      // start outranks everything, including an fe in the same cycle.
      if (start) begin
         state_d     = (DISCARD_N == 0) ? StAccum : StDiscard;
         acc_d       = '0;
         n_d         = '0;
         dcnt_d      = '0;
         tcnt_d      = '0;
         avg_valid_d = 1'b0;
         timeout_d   = 1'b0;
      end else begin
         unique case (state_q)
            StDiscard, StAccum: begin
               if (fe) begin
                  tcnt_d = '0;
                  if (state_q == StDiscard) begin
                     dcnt_d = dcnt_q + 4'd1;
                     if (dcnt_q == DcntLast) state_d = StAccum;
                  end else begin
                     acc_d = acc_q + AccW'(vpp_in);
                     n_d   = n_q + NW'(1);
                     if (n_q == NLast) state_d = StDone;
                  end
               end else if (tcnt_q == TcntLast) begin
                  state_d     = StIdle;
                  timeout_d   = 1'b1;
                  avg_valid_d = 1'b0;
               end else begin
                  tcnt_d = tcnt_q + TcntW'(1);
               end
            end
            StDone: begin
               vpp_avg_d   = avg_calc;
               avg_valid_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sync_q      <= '0;
         acc_q       <= '0;
         n_q         <= '0;
         dcnt_q      <= '0;
         tcnt_q      <= '0;
         vpp_avg_q   <= '0;
         avg_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= {sync_q[1:0], vpp_found};
         acc_q       <= acc_d;
         n_q         <= n_d;
         dcnt_q      <= dcnt_d;
         tcnt_q      <= tcnt_d;
         vpp_avg_q   <= vpp_avg_d;
         avg_valid_q <= avg_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign vpp_avg   = vpp_avg_q;
   assign avg_valid = avg_valid_q;
   assign timeout   = timeout_q;
   assign busy      = (state_q == StDiscard) || (state_q == StAccum);

endmodule

// File: tb/tb_vpp_avg_filter.sv
// Bench for vpp_avg_filter: measurement-level reference model checked every cycle,
// directed literal cases, and an unrelated-clock strobe run.
module tb_vpp_avg_filter;

   localparam int DATA_W    = 12;
   localparam int AVG_LOG2  = 3;
   localparam int DISCARD_N = 2;
   localparam int TO_CYC    = 1000;
   localparam int MAXV      = (1 << DATA_W) - 1;
   localparam int NAVG      = 1 << AVG_LOG2;
`ifdef VPP_AVG_ROUND_EN
   localparam int T2_EXP = 1004;
`else
   localparam int T2_EXP = 1003;
`endif

   logic              clk = 1'b0;
   logic              clk_s = 1'b0;
   logic              rst_n;
   logic              start;
   logic [DATA_W-1:0] vpp_in;
   logic              vpp_found;
   logic [DATA_W-1:0] vpp_avg;
   logic              avg_valid;
   logic              busy;
   logic              timeout;

   int n_chk  = 0;
   int n_pass = 0;
   bit run    = 1'b0;

   // Reference model state: one measurement as a list of accepted samples.
   bit [2:0] hist = '0;
   int       m_q[$];
   int       m_disc = 0;
   int       m_idle = 0;
   bit       m_active = 1'b0;
   bit       m_pend = 1'b0;
   bit       m_valid = 1'b0;
   bit       m_to = 1'b0;
   int       m_avg = 0;

   always #50 clk = ~clk;
   always #135 clk_s = ~clk_s;

   vpp_avg_filter #(
      .DATA_W      (DATA_W),
      .AVG_LOG2    (AVG_LOG2),
      .DISCARD_N   (DISCARD_N),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vpp_in    (vpp_in),
      .vpp_found (vpp_found),
      .vpp_avg   (vpp_avg),
      .avg_valid (avg_valid),
      .busy      (busy),
      .timeout   (timeout)
   );

   function automatic int exp_avg(input int sum);
`ifdef VPP_AVG_ROUND_EN
      int r;
      r = (sum + (1 << (AVG_LOG2 - 1))) >> AVG_LOG2;
      return (r > MAXV) ? MAXV : r;
`else
      return sum >> AVG_LOG2;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Strobe high for 2 clk; start pulses on iteration soff (2 = same cycle as the fe).
   task automatic pulse(input int v, input int low, input int soff);
      vpp_in    = DATA_W'(v);
      vpp_found = 1'b1;
      for (int k = 0; k < 2 + low; k++) begin
         start = (k == soff);
         if (k == 2) vpp_found = 1'b0;
         tick(1);
      end
      start = 1'b0;
   endtask

   // Model: fe seen for a clock cycle when the strobe was sampled high two edges
   // earlier and low three edges earlier.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         hist = '0; m_q.delete(); m_disc = 0; m_idle = 0;
         m_active = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_to = 1'b0; m_avg = 0;
      end else begin
         bit fe;
         fe = hist[1] & ~hist[2];
         hist = {hist[1:0], vpp_found};
         if (m_pend && !start) begin
            m_valid = 1'b1;
            m_avg   = exp_avg(m_q.sum());
         end
         m_pend = 1'b0;
         if (start) begin
            m_q.delete(); m_disc = 0; m_idle = 0;
            m_active = 1'b1; m_valid = 1'b0; m_to = 1'b0;
         end else if (m_active) begin
            if (fe) begin
               m_idle = 0;
               if (m_disc < DISCARD_N) m_disc++;
               else begin
                  m_q.push_back(int'(vpp_in));
                  if (m_q.size() == NAVG) begin
                     m_active = 1'b0;
                     m_pend   = 1'b1;
                  end
               end
            end else begin
               m_idle++;
               if (m_idle == TO_CYC) begin
                  m_active = 1'b0; m_to = 1'b1; m_valid = 1'b0;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (run) begin
         chk("busy", int'(busy), int'(m_active));
         chk("avg_valid", int'(avg_valid), int'(m_valid));
         chk("timeout", int'(timeout), int'(m_to));
         chk("vpp_avg", int'(vpp_avg), m_avg);
      end
   end

   initial begin
      int sum;
      int v;
      int np;
      int soff;
      rst_n = 1'b1; start = 1'b0; vpp_in = '0; vpp_found = 1'b0;
      #10 rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      run = 1'b1;
      tick(2);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(avg_valid), 0);
      chk("rst_avg", int'(vpp_avg), 0);

      // Two settling samples, then eight averaged.
      do_start;
      pulse(100, 3, -1);
      pulse(100, 3, -1);
      for (int i = 0; i < 8; i++) pulse(1000 + i, 3, -1);
      tick(4);
      chk("t2_avg", int'(vpp_avg), T2_EXP);
      chk("t2_valid", int'(avg_valid), 1);
      chk("t2_busy", int'(busy), 0);

      do_start;
      for (int i = 0; i < 10; i++) pulse(MAXV, 3, -1);
      tick(4);
      chk("t3_sat", int'(vpp_avg), MAXV);

      do_start;
      for (int i = 0; i < 5; i++) pulse(777, 3, -1);
      do_start;
      for (int i = 0; i < 10; i++) pulse(500, 3, -1);
      tick(4);
      chk("t4_restart", int'(vpp_avg), 500);
      chk("t4_valid", int'(avg_valid), 1);

      do_start;
      tick(3);
      pulse(4000, 3, 2);
      pulse(100, 3, -1);
      pulse(100, 3, -1);
      for (int i = 0; i < 8; i++) pulse(200, 3, -1);
      tick(4);
      chk("t4_start_fe", int'(vpp_avg), 200);

      do_start;
      for (int i = 0; i < 4; i++) pulse(100, 3, -1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_busy", int'(busy), 0);
      chk("t1_valid", int'(avg_valid), 0);
      chk("t1_avg", int'(vpp_avg), 0);
      chk("t1_timeout", int'(timeout), 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("t1_idle", int'(busy), 0);

      // Third strobe rises before edge A; its fe clears the counter at A+2,
      // so timeout must appear exactly at edge A+1002.
      do_start;
      pulse(50, 3, -1);
      pulse(50, 3, -1);
      vpp_in = DATA_W'(50);
      vpp_found = 1'b1;
      for (int k = 1; k <= 1003; k++) begin
         tick(1);
         if (k == 2) vpp_found = 1'b0;
         if (k == 1002) begin
            chk("t5_pre_timeout", int'(timeout), 0);
            chk("t5_pre_busy", int'(busy), 1);
         end
         if (k == 1003) begin
            chk("t5_timeout", int'(timeout), 1);
            chk("t5_busy", int'(busy), 0);
            chk("t5_valid", int'(avg_valid), 0);
         end
      end

      for (int m = 0; m < 40; m++) begin
         do_start;
         np = int'($urandom_range(0, 12));
         for (int p = 0; p < np; p++) begin
            soff = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            pulse(int'($urandom_range(0, MAXV)), int'($urandom_range(2, 6)), soff);
         end
         if (m % 7 == 3) tick(TO_CYC + 10);
         tick(int'($urandom_range(0, 5)));
      end

      // Strobe from an unrelated slow clock; a lost or doubled fe shifts the window.
      for (int m = 0; m < 100; m++) begin
         do_start;
         tick(2);
         sum = 0;
         for (int p = 0; p < 10; p++) begin
            @(negedge clk_s);
            v = int'($urandom_range(0, MAXV));
            vpp_in = DATA_W'(v);
            if (p >= DISCARD_N) sum += v;
            @(posedge clk_s);
            vpp_found = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk_s);
            vpp_found = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk_s);
         end
         tick(8);
         chk("cdc_valid", int'(avg_valid), 1);
         chk("cdc_avg", int'(vpp_avg), exp_avg(sum));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
